// File: rtl/wimax_pkg.sv
// rtl/wimax_pkg.sv - shared types and constants for the WiMAX QPSK burst path
//
// Purpose: burst-controller FSM state type, OFDM/QPSK sizing constants and a
// counter-width helper.
// Ports: none (package).
package wimax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } qpsk_bctrl_state_t;

  localparam int N_DATA_SC        = 192;
  localparam int QPSK_BITS_PER_SC = 2;
  localparam int BITS_PER_SYM_DEF = N_DATA_SC * QPSK_BITS_PER_SC;

  // Register width needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bctrl_counter.sv
// rtl/bctrl_counter.sv - synchronous up-counter with clear, enable and terminal wrap
//
// Purpose: counts enabled cycles and wraps to zero on the enabled cycle where
// the count equals max_i. clr_i has priority over en_i.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   clr_i  in   force count to zero
//   en_i   in   advance count
//   max_i  in   terminal value; the count wraps after it
//   cnt_o  out  current count
module bctrl_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == max_i) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/qpsk_burst_ctrl.sv
// rtl/qpsk_burst_ctrl.sv - burst sequencer between interleaver and QPSK modulator
//
// Purpose: accepts a burst command (number of OFDM symbols), gates exactly
// BITS_PER_SYM bits per symbol from the interleaver to the modulator with a
// zero-latency pass-through, inserts GAP_CYCLES idle cycles between symbols,
// and flags symbol/burst boundaries on each transferred bit.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          burst command handshake
//   cmd_num_sym                  symbols in the burst (0 = empty burst)
//   i_abort                      synchronous burst abort
//   s_valid/s_data/s_ready       interleaver bit stream in
//   m_valid/m_data/m_ready       modulator bit stream out
//   m_sob/m_sos/m_eos/m_eob      boundary markers, qualified by m_valid
//   busy, done, aborted          status; done pulses once per burst end
//   sym_idx                      index of the current OFDM symbol
module qpsk_burst_ctrl
  import wimax_pkg::*;
#(
  parameter int BITS_PER_SYM = BITS_PER_SYM_DEF,
  parameter int GAP_CYCLES   = 16,
  parameter int NSYM_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [NSYM_W-1:0] cmd_num_sym,
  input  logic              i_abort,
  input  logic              s_valid,
  input  logic              s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic              m_data,
  input  logic              m_ready,
  output logic              m_sob,
  output logic              m_sos,
  output logic              m_eos,
  output logic              m_eob,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [NSYM_W-1:0] sym_idx
);

  localparam int BIT_W = cnt_width(BITS_PER_SYM);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BITS_PER_SYM - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Odd symbol sizes would split a QPSK bit pair across symbols.
  generate
    if ((BITS_PER_SYM < 2) || ((BITS_PER_SYM % 2) != 0)) begin : g_bad_bits_per_sym
      $error("qpsk_burst_ctrl: BITS_PER_SYM must be even and >= 2");
    end
  endgenerate

  qpsk_bctrl_state_t state_q, state_d;
  logic [NSYM_W-1:0] num_sym_q, num_sym_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [NSYM_W-1:0] sym_cnt;
  logic [NSYM_W-1:0] sym_max;

  logic in_idle, in_run, in_gap, in_done;
  logic accept, xfer, cnt_clr;
  logic bit_tc, sym_last, gap_tc;

  assign in_idle = (state_q == IDLE);
  assign in_run  = (state_q == RUN);
  assign in_gap  = (state_q == GAP);
  assign in_done = (state_q == DONE);

  assign accept  = in_idle & cmd_valid;
  assign xfer    = s_valid & m_ready & in_run & ~i_abort;

  // Counters restart on a new command and again on the way back to IDLE,
  // so an aborted burst leaves nothing stale behind.
  assign cnt_clr = accept | in_done;

  assign sym_max  = num_sym_q - 1'b1;
  assign bit_tc   = (bit_cnt == BIT_MAX);
  assign sym_last = (sym_cnt == sym_max);
  assign gap_tc   = (gap_cnt == GAP_MAX);

  bctrl_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (xfer),
    .max_i (BIT_MAX),
    .cnt_o (bit_cnt)
  );

  bctrl_counter #(.WIDTH(NSYM_W)) u_sym_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (xfer & bit_tc),
    .max_i (sym_max),
    .cnt_o (sym_cnt)
  );

  bctrl_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (in_gap & ~i_abort),
    .max_i (GAP_MAX),
    .cnt_o (gap_cnt)
  );

  always_comb begin
    state_d   = state_q;
    num_sym_d = num_sym_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_num_sym != '0) begin
            num_sym_d = cmd_num_sym;
            state_d   = RUN;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (xfer && bit_tc) begin
          if (sym_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (i_abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (gap_tc) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_sym_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_sym_q <= num_sym_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Handshakes are forced low while rst is high, before the state register
  // has had a chance to return to IDLE.
  assign cmd_ready = in_idle & ~rst;
  assign s_ready   = m_ready & in_run & ~i_abort & ~rst;
  assign m_valid   = s_valid & in_run & ~i_abort & ~rst;
  assign m_data    = s_data;

  assign m_sos   = m_valid & (bit_cnt == '0);
  assign m_eos   = m_valid & bit_tc;
  assign m_sob   = m_sos & (sym_cnt == '0);
  assign m_eob   = m_eos & sym_last;

  assign busy    = ~in_idle;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign sym_idx = sym_cnt;

endmodule

// File: doc/qpsk_burst_ctrl.md
Name: qpsk_burst_ctrl

Overview:
- Burst sequencer between the interleaver bit stream and the QPSK modulator.
- Accepts a burst command giving a number of OFDM symbols. Gates exactly BITS_PER_SYM bits per OFDM symbol from the interleaver into the modulator's bit input.
- Inserts a fixed idle gap between OFDM symbols for IFFT/CP loading.
- Emits symbol/burst boundary markers aligned to each transferred bit.

Parameters:
- BITS_PER_SYM, 384, bits per OFDM symbol (192 data subcarriers x 2 bits); must be even and >= 2. Elaboration-time assertion.
- GAP_CYCLES, 16, idle cycles between consecutive OFDM symbols within a burst; 0 allowed.
- NSYM_W, 8, width of the symbol-count field.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, synchronous active-high reset.
- cmd_valid, input, 1, burst command valid.
- cmd_ready, output, 1, controller can accept a command.
- cmd_num_sym, input, NSYM_W, number of OFDM symbols in the burst.
- i_abort, input, 1, synchronous burst abort.
- s_valid, input, 1, interleaver bit valid.
- s_data, input, 1, interleaver bit.
- s_ready, output, 1, ready to interleaver.
- m_valid, output, 1, bit valid to modulator.
- m_data, output, 1, bit to modulator.
- m_ready, input, 1, modulator ready.
- m_sob, output, 1, current bit is the first bit of the burst.
- m_sos, output, 1, current bit is the first bit of an OFDM symbol.
- m_eos, output, 1, current bit is the last bit of an OFDM symbol.
- m_eob, output, 1, current bit is the last bit of the burst.
- busy, output, 1, state is not IDLE.
- done, output, 1, one-cycle pulse at burst end.
- aborted, output, 1, qualifies done: burst ended by i_abort.
- sym_idx, output, NSYM_W, index of the current OFDM symbol.

Behaviour:
- Interface: one clock, clk. rst is synchronous, active-high, sampled on posedge clk.
- Reset state: IDLE. Registered outputs reset to zero: done, aborted, sym_idx, bit counter, gap counter, latched num_sym.
- While rst is high, cmd_ready, s_ready and m_valid are 0.
- States are IDLE, RUN, GAP, DONE.
- Datapath is combinational pass-through with zero latency:
  - m_data = s_data.
  - m_valid = s_valid & (state==RUN) & ~i_abort.
  - s_ready = m_ready & (state==RUN) & ~i_abort.
  - A transfer (xfer) occurs when s_valid & m_ready & (state==RUN) & ~i_abort.
- Markers are valid only when m_valid=1, and are 0 otherwise:
  - m_sos = (bit_cnt==0).
  - m_eos = (bit_cnt==BITS_PER_SYM-1).
  - m_sob = m_sos & (sym_idx==0).
  - m_eob = m_eos & (sym_idx==num_sym-1).
- IDLE:
  - cmd_ready=1.
  - cmd_valid=1 with cmd_num_sym>0: latch num_sym, clear counters, go to RUN.
  - cmd_valid=1 with cmd_num_sym==0: go to DONE with no bits transferred.
- RUN: each xfer increments bit_cnt. On an xfer with bit_cnt==BITS_PER_SYM-1:
  - bit_cnt wraps to 0.
  - If sym_idx==num_sym-1, go to DONE.
  - Else increment sym_idx; go to GAP if GAP_CYCLES>0, otherwise stay in RUN.
- GAP:
  - s_ready=0 and m_valid=0 for exactly GAP_CYCLES cycles, counted by gap_cnt, then return to RUN.
  - m_ready is ignored during GAP.
- DONE:
  - Lasts exactly one cycle: done=1, aborted per the cause, then go to IDLE.
  - cmd_ready=0 in DONE, so back-to-back bursts have a 1-cycle bubble minimum.
- i_abort:
  - In RUN or GAP: blocks the transfer that cycle, then go to DONE with aborted=1. Counters are cleared on the IDLE entry.
  - In IDLE or DONE: ignored.
  - Abort in the same cycle as a would-be last bit: abort wins and the bit is not transferred.
- Backpressure: m_ready=0 or s_valid=0 in RUN stalls the counters; no bit is dropped or duplicated.
- Bit-pair alignment: BITS_PER_SYM is even, so every OFDM symbol begins on a modulator pair boundary.
- Mid-operation rst: immediate return to IDLE. No done pulse.
- busy=1 in RUN, GAP and DONE.

Decomposition:
- wimax_pkg gets:
  - typedef enum qpsk_bctrl_state_t {IDLE, RUN, GAP, DONE}.
  - Constants N_DATA_SC=192 and QPSK_BITS_PER_SC=2, with BITS_PER_SYM default derived from them.
- One sub-module: bctrl_counter, a parameterised synchronous up-counter with clear/enable/terminal-count. It is instantiated for bit_cnt, sym_idx and gap_cnt.
- The FSM stays in the top module.

Test Plan:
- Single burst, default parameters: cmd_num_sym=2, s_valid and m_ready held 1.
  - Expect exactly 768 transfers.
  - m_sob on bit 0; m_sos on bits 0 and 384; m_eos on bits 383 and 767; m_eob on bit 767.
  - Exactly 16 gap cycles after bit 383.
  - done pulses once, with aborted=0.
- Random m_ready/s_valid backpressure (~30% low), cmd_num_sym=3: expect 1152 transfers, output bit sequence identical to input, marker positions unchanged.
- cmd_num_sym=0: expect no m_valid, done=1 exactly one cycle after acceptance, cmd_ready=1 again the cycle after.
- i_abort asserted during the bit-100 transfer cycle of symbol 1: expect that bit not transferred (s_ready=0), then done=1 with aborted=1, then IDLE.
- rst pulsed mid-GAP: expect IDLE, busy=0, no done pulse; the next command runs a full correct burst.
- GAP_CYCLES=0, BITS_PER_SYM=4, cmd_num_sym=3: expect 12 contiguous transfers, m_eos every 4th bit, m_eob on bit 11; a cmd_valid held high is re-accepted after a 1-cycle DONE.
